fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the fetch stage: decides each cycle whether the PC register advances, holds or is redirected (branch, exception, RTI).
- Drives the fetch stage's pcWriteEN / pcSel / pcNext inputs.
- Issues read requests to a variable-latency instruction memory (stall/done handshake) and flags valid instructions to decode.
- Owns EPC, halt/dump sequencing, and a fetch-timeout watchdog.

Parameters:
EXC_VECTOR, 16'h0002, PC loaded on exception or fetch timeout
MAX_WAIT, 8, max cycles in WAIT before timeout (counter width 4 bits; MAX_WAIT must be 1..15)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
pc_current  in  16  PC register value from fetch stage
imem_stall  in  1  instruction memory busy; request not accepted this cycle
imem_done  in  1  instruction memory returns data this cycle
hazard_stall  in  1  decode requests fetch freeze
branch_taken  in  1  redirect request from execute
branch_target  in  16  redirect address
exception  in  1  exception raised by pipeline
rti  in  1  return from exception
halt  in  1  HALT decoded
pc_write_en  out  1  to fetch pcWriteEN
pc_sel  out  1  to fetch pcSel (1 = load pc_next, 0 = PC+2)
pc_next  out  16  redirect target; 16'h0000 when pc_sel=0
imem_rd  out  1  instruction memory read request
instr_valid  out  1  fetched instruction valid for decode
epc  out  16  saved exception PC
mem_timeout  out  1  one-cycle pulse on watchdog expiry
halted  out  1  level, high in HALT
dump  out  1  one-cycle pulse on HALT entry

Behaviour:
- All outputs combinational from state/inputs except epc, halted, dump (registered).
- Reset: state=IDLE; epc=0; pending redirect cleared; wait counter=0; every output 0.
- States: IDLE, REQ, WAIT, HALT.
- IDLE: no request; next state REQ unconditionally (unless halt=1 -> HALT).
- REQ, hazard_stall=0:
  - imem_rd=1.
  - If imem_stall=1: request not accepted; stay in REQ; pc_write_en=0.
  - If accepted with imem_done=1 (same-cycle hit): instr_valid=1, pc_write_en=1, stay in REQ.
  - If accepted with imem_done=0: go to WAIT, counter=0.
- REQ, hazard_stall=1: imem_rd=0, instr_valid=0, pc_write_en=0; stay in REQ.
- WAIT:
  - imem_rd=0; counter increments each cycle.
  - On imem_done: instr_valid=1 unless a redirect is pending; pc_write_en=1; go to REQ.
  - If counter reaches MAX_WAIT with no done: mem_timeout=1, epc<=pc_current, redirect to EXC_VECTOR, go to REQ. Any done arriving later is ignored.
- Redirect priority on the PC-update cycle: exception > rti > branch_taken > sequential.
  - Exception: epc<=pc_current, pc_next=EXC_VECTOR.
  - rti: pc_next=epc.
  - branch: pc_next=branch_target.
  - Any redirect sets pc_sel=1 and pc_write_en=1.
- Redirect in IDLE or REQ: applied the same cycle, even under hazard_stall or imem_stall (flush overrides stall). instr_valid=0 in that cycle.
- Redirect in WAIT: latched into a pending register (target plus epc capture for exceptions). A later, higher-priority redirect overwrites a lower one. Applied on the completing done cycle; that fetch is squashed (instr_valid=0).
- halt in IDLE or REQ: next state HALT; dump=1 for exactly one cycle; halted=1.
- halt in WAIT: outstanding access completes (instr_valid=0), then HALT.
- HALT: pc_write_en=0, imem_rd=0, instr_valid=0; all inputs ignored; exit only by rst.
- halt has lower priority than exception in the same cycle: the exception redirect is taken and halt is dropped.
- rst asserted mid-WAIT: immediately returns to IDLE. An imem_done arriving after reset is ignored (not in WAIT).
- Counter saturates; never wraps.

Test Plan:
- Reset: rst high 2 cycles -> all outputs 0; cycle 1 after release IDLE; cycle 2 imem_rd=1.
- Hit stream: imem_done=1 on every request, pc_current 0,2,4 -> instr_valid=1 and pc_write_en=1 each cycle, pc_sel=0.
- Miss: done arrives 3 cycles after request -> imem_rd for 1 cycle, then 2 cycles with pc_write_en=0 and instr_valid=0, then pc_write_en=1 and instr_valid=1 on the done cycle.
- Branch in WAIT: branch_target=16'h0040, done 2 cycles later -> on the done cycle pc_sel=1, pc_next=16'h0040, instr_valid=0.
- Exception plus branch same cycle in REQ, pc_current=16'h0010 -> pc_next=16'h0002; epc=16'h0010 next cycle. Then rti -> pc_next=16'h0010.
- Timeout: no done for 8 WAIT cycles -> mem_timeout pulse, pc_next=16'h0002.
- halt -> dump high 1 cycle, halted stays 1; later branch_taken ignored, pc_write_en=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Decides each cycle whether the PC
// advances, holds or is redirected; handshakes with a variable-latency
// instruction memory; owns EPC, the halt/dump sequence and a fetch watchdog.
module fetch_ctrl #(
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_current,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        exception,
  input  logic        rti,
  input  logic        halt,
  output logic        pc_write_en,
  output logic        pc_sel,
  output logic [15:0] pc_next,
  output logic        imem_rd,
  output logic        instr_valid,
  output logic [15:0] epc,
  output logic        mem_timeout,
  output logic        halted,
  output logic        dump
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_t;

  // Encoded so that a larger value means a higher-priority redirect.
  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_RTI    = 2'd2,
    RD_EXC    = 2'd3
  } redir_t;

  state_t      state_q, state_next;
  logic [15:0] epc_q, epc_next;
  redir_t      pend_kind_q, pend_kind_next;
  logic [15:0] pend_target_q, pend_target_next;
  logic [15:0] pend_epc_q, pend_epc_next;
  logic [3:0]  wait_cnt_q, wait_cnt_next;
  logic        halt_pend_q, halt_pend_next;
  logic        halted_q, dump_q;

  redir_t      in_kind;
  logic [15:0] in_target;
  logic        take_in;
  redir_t      mrg_kind;
  logic [15:0] mrg_target;
  logic [15:0] mrg_epc;
  logic [3:0]  cnt_inc;
  logic        halt_any;

  // Classify this cycle's redirect request by priority.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    in_kind   = RD_NONE;
    in_target = 16'h0000;
    if (exception) begin
      in_kind   = RD_EXC;
      in_target = EXC_VECTOR;
    end else if (rti) begin
      in_kind   = RD_RTI;
      in_target = epc_q;
    end else if (branch_taken) begin
      in_kind   = RD_BRANCH;
      in_target = branch_target;
    end
  end

  // A new redirect replaces the pending one unless the pending one outranks it.
  assign take_in    = (in_kind >= pend_kind_q);
  assign mrg_kind   = take_in ? in_kind   : pend_kind_q;
  assign mrg_target = take_in ? in_target : pend_target_q;
  assign mrg_epc    = take_in ? pc_current : pend_epc_q;

  // Wait counter saturates at MAX_CNT rather than wrapping.
  assign cnt_inc  = (wait_cnt_q == MAX_CNT) ? MAX_CNT : wait_cnt_q + 4'd1;
  assign halt_any = halt_pend_q | halt;

  // Next-state and combinational outputs.
  always_comb begin
    state_next       = state_q;
    epc_next         = epc_q;
    pend_kind_next   = pend_kind_q;
    pend_target_next = pend_target_q;
    pend_epc_next    = pend_epc_q;
    wait_cnt_next    = wait_cnt_q;
    halt_pend_next   = halt_pend_q;
    pc_write_en      = 1'b0;
    pc_sel           = 1'b0;
    pc_next          = 16'h0000;
    imem_rd          = 1'b0;
    instr_valid      = 1'b0;
    mem_timeout      = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_next = REQ;
        if (in_kind != RD_NONE) begin
          pc_write_en = 1'b1;
          pc_sel      = 1'b1;
          pc_next     = in_target;
          if (in_kind == RD_EXC) epc_next = pc_current;
        end
        // An exception in the same cycle drops the halt.
        if (halt && in_kind != RD_EXC) state_next = HALT;
      end

      REQ: begin
        if (in_kind != RD_NONE) begin
          // Flush overrides both stalls; the wrong-path fetch is not issued.
          pc_write_en = 1'b1;
          pc_sel      = 1'b1;
          pc_next     = in_target;
          if (in_kind == RD_EXC) epc_next = pc_current;
          if (halt && in_kind != RD_EXC) state_next = HALT;
        end else if (halt) begin
          state_next = HALT;
        end else if (!hazard_stall) begin
          imem_rd = 1'b1;
          if (!imem_stall) begin
            if (imem_done) begin
              instr_valid = 1'b1;
              pc_write_en = 1'b1;
            end else begin
              state_next    = WAIT;
              wait_cnt_next = 4'd0;
            end
          end
        end
      end

      WAIT: begin
        wait_cnt_next = cnt_inc;
        if (halt) halt_pend_next = 1'b1;
        if (take_in && in_kind != RD_NONE) begin
          pend_kind_next   = in_kind;
          pend_target_next = in_target;
          pend_epc_next    = pc_current;
        end
        if (imem_done) begin
          pc_write_en = 1'b1;
          if (mrg_kind != RD_NONE) begin
            pc_sel  = 1'b1;
            pc_next = mrg_target;
            if (mrg_kind == RD_EXC) epc_next = mrg_epc;
          end
          // Squash the returning fetch if it is on a dead path or we are halting.
          instr_valid      = (mrg_kind == RD_NONE) && !halt_any;
          state_next       = (halt_any && mrg_kind != RD_EXC) ? HALT : REQ;
          pend_kind_next   = RD_NONE;
          pend_target_next = 16'h0000;
          pend_epc_next    = 16'h0000;
          halt_pend_next   = 1'b0;
          wait_cnt_next    = 4'd0;
        end else if (cnt_inc == MAX_CNT) begin
          // Watchdog expiry behaves as an exception and abandons the access.
          mem_timeout      = 1'b1;
          pc_write_en      = 1'b1;
          pc_sel           = 1'b1;
          pc_next          = EXC_VECTOR;
          epc_next         = pc_current;
          state_next       = REQ;
          pend_kind_next   = RD_NONE;
          pend_target_next = 16'h0000;
          pend_epc_next    = 16'h0000;
          halt_pend_next   = 1'b0;
          wait_cnt_next    = 4'd0;
        end
      end

      HALT: begin
        state_next = HALT;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Every output is quiet while reset is held.
    if (rst) begin
      pc_write_en = 1'b0;
      pc_sel      = 1'b0;
      pc_next     = 16'h0000;
      imem_rd     = 1'b0;
      instr_valid = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  // State, EPC, pending redirect and halt/dump registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (rst) begin
      state_q       <= IDLE;
      epc_q         <= 16'h0000;
      pend_kind_q   <= RD_NONE;
      pend_target_q <= 16'h0000;
      pend_epc_q    <= 16'h0000;
      wait_cnt_q    <= 4'd0;
      halt_pend_q   <= 1'b0;
      halted_q      <= 1'b0;
      dump_q        <= 1'b0;
    end else begin
      state_q       <= state_next;
      epc_q         <= epc_next;
      pend_kind_q   <= pend_kind_next;
      pend_target_q <= pend_target_next;
      pend_epc_q    <= pend_epc_next;
      wait_cnt_q    <= wait_cnt_next;
      halt_pend_q   <= halt_pend_next;
      halted_q      <= (state_next == HALT);
      dump_q        <= (state_next == HALT) && (state_q != HALT);
    end
  end

  assign epc    = epc_q;
  assign halted = halted_q;
  assign dump   = dump_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: cycle-by-cycle directed vectors for fetch_ctrl. Each record
// holds one cycle's inputs and the outputs expected during that cycle.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_current = '0;
  logic        imem_stall = 1'b0;
  logic        imem_done = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        exception = 1'b0;
  logic        rti = 1'b0;
  logic        halt = 1'b0;
  logic        pc_write_en, pc_sel, imem_rd, instr_valid, mem_timeout, halted, dump;
  logic [15:0] pc_next, epc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.EXC_VECTOR(16'h0002), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .pc_current(pc_current),
    .imem_stall(imem_stall), .imem_done(imem_done), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exception(exception), .rti(rti), .halt(halt),
    .pc_write_en(pc_write_en), .pc_sel(pc_sel), .pc_next(pc_next),
    .imem_rd(imem_rd), .instr_valid(instr_valid), .epc(epc),
    .mem_timeout(mem_timeout), .halted(halted), .dump(dump)
  );

  // Expected bundle layout: {we, sel, pc_next, rd, iv, epc, timeout, halted, dump}
  typedef struct {
    string       name;
    logic        r;
    logic [15:0] pc;
    logic        st, dn, hz, br;
    logic [15:0] tg;
    logic        ex, rt, hl;
    logic [38:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic r, input logic [15:0] pc,
                              input logic st, dn, hz, br, input logic [15:0] tg,
                              input logic ex, rt, hl,
                              input logic we, sl, input logic [15:0] nx,
                              input logic rd, iv, input logic [15:0] ep,
                              input logic to, ht, dp);
    vec_t v;
    v.name = nm; v.r = r; v.pc = pc; v.st = st; v.dn = dn; v.hz = hz; v.br = br;
    v.tg = tg; v.ex = ex; v.rt = rt; v.hl = hl;
    v.exp = {we, sl, nx, rd, iv, ep, to, ht, dp};
    return v;
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got we=%b sel=%b nxt=%h rd=%b iv=%b epc=%h to=%b hlt=%b dmp=%b, expected we=%b sel=%b nxt=%h rd=%b iv=%b epc=%h to=%b hlt=%b dmp=%b",
               name, act[38], act[37], act[36:21], act[20], act[19], act[18:3], act[2], act[1], act[0],
               exp[38], exp[37], exp[36:21], exp[20], exp[19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs just after.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.r; pc_current = v.pc; imem_stall = v.st; imem_done = v.dn;
    hazard_stall = v.hz; branch_taken = v.br; branch_target = v.tg;
    exception = v.ex; rti = v.rt; halt = v.hl;
    #1;
    check(v.name, {pc_write_en, pc_sel, pc_next, imem_rd, instr_valid, epc,
                   mem_timeout, halted, dump}, v.exp);
  endtask

  // Hold reset across one rising edge without checking.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_stall = 1'b0; imem_done = 1'b0; hazard_stall = 1'b0;
    branch_taken = 1'b0; exception = 1'b0; rti = 1'b0; halt = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //                    rst pc        st dn hz br tgt        ex rt hl  we sl nxt        rd iv epc        to ht dp
    tbl.push_back(mk("rst_hold",   1, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("idle",       0, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("hit_pc0",    0, 16'h0000, 0,1,0,0, 16'h0000, 0,0,0, 1,0,16'h0000, 1,1,16'h0000, 0,0,0));
    tbl.push_back(mk("hit_pc2",    0, 16'h0002, 0,1,0,0, 16'h0000, 0,0,0, 1,0,16'h0000, 1,1,16'h0000, 0,0,0));
    tbl.push_back(mk("hit_pc4",    0, 16'h0004, 0,1,0,0, 16'h0000, 0,0,0, 1,0,16'h0000, 1,1,16'h0000, 0,0,0));
    tbl.push_back(mk("miss_req",   0, 16'h0006, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 1,0,16'h0000, 0,0,0));
    tbl.push_back(mk("miss_w1",    0, 16'h0006, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("miss_w2",    0, 16'h0006, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("miss_done",  0, 16'h0006, 0,1,0,0, 16'h0000, 0,0,0, 1,0,16'h0000, 0,1,16'h0000, 0,0,0));
    tbl.push_back(mk("imem_stall", 0, 16'h0008, 1,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 1,0,16'h0000, 0,0,0));
    tbl.push_back(mk("hazard",     0, 16'h0008, 0,1,1,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("br_req",     0, 16'h0008, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 1,0,16'h0000, 0,0,0));
    tbl.push_back(mk("br_in_wait", 0, 16'h0008, 0,0,0,1, 16'h0040, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("br_wait2",   0, 16'h0008, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("br_done",    0, 16'h0008, 0,1,0,0, 16'h0000, 0,0,0, 1,1,16'h0040, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("exc_br_req", 0, 16'h0010, 0,0,0,1, 16'h0040, 1,0,0, 1,1,16'h0002, 0,0,16'h0000, 0,0,0));
    tbl.push_back(mk("rti",        0, 16'h0002, 0,0,0,0, 16'h0000, 0,1,0, 1,1,16'h0010, 0,0,16'h0010, 0,0,0));
    tbl.push_back(mk("br_hazard",  0, 16'h0010, 0,0,1,1, 16'h0100, 0,0,0, 1,1,16'h0100, 0,0,16'h0010, 0,0,0));
    tbl.push_back(mk("exc_w_req",  0, 16'h0100, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 1,0,16'h0010, 0,0,0));
    tbl.push_back(mk("exc_w_exc",  0, 16'h0100, 0,0,0,0, 16'h0000, 1,0,0, 0,0,16'h0000, 0,0,16'h0010, 0,0,0));
    tbl.push_back(mk("exc_w_br",   0, 16'h0104, 0,0,0,1, 16'h0200, 0,0,0, 0,0,16'h0000, 0,0,16'h0010, 0,0,0));
    tbl.push_back(mk("exc_w_done", 0, 16'h0104, 0,1,0,0, 16'h0000, 0,0,0, 1,1,16'h0002, 0,0,16'h0010, 0,0,0));
    tbl.push_back(mk("exc_w_epc",  0, 16'h0002, 0,0,1,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0100, 0,0,0));
    tbl.push_back(mk("halt_req",   0, 16'h0002, 0,0,0,0, 16'h0000, 0,0,1, 0,0,16'h0000, 0,0,16'h0100, 0,0,0));
    tbl.push_back(mk("halt_dump",  0, 16'h0002, 0,0,0,1, 16'h0040, 0,0,0, 0,0,16'h0000, 0,0,16'h0100, 0,1,1));
    tbl.push_back(mk("halt_stay",  0, 16'h0002, 0,1,0,0, 16'h0000, 1,0,0, 0,0,16'h0000, 0,0,16'h0100, 0,1,0));

    // Initial reset edge, then the table starts in the second reset cycle.
    rst = 1'b1;
    @(posedge clk);
    foreach (tbl[i]) apply(tbl[i]);

    // Watchdog: eight WAIT cycles without done, then a late done is ignored.
    do_reset();
    apply(mk("to_rst",  1, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("to_idle", 0, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("to_req",  0, 16'h0030, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 1,0,16'h0000, 0,0,0));
    for (int i = 1; i <= 8; i++) begin
      if (i < 8)
        apply(mk($sformatf("to_wait%0d", i), 0, 16'h0030, 0,0,0,0, 16'h0000, 0,0,0,
                 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
      else
        apply(mk("to_expire", 0, 16'h0030, 0,0,0,0, 16'h0000, 0,0,0,
                 1,1,16'h0002, 0,0,16'h0000, 1,0,0));
    end
    apply(mk("to_late_done", 0, 16'h0002, 0,1,1,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0030, 0,0,0));

    // Reset in the middle of WAIT; a done after reset is ignored.
    do_reset();
    apply(mk("rw_rst",   1, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("rw_idle",  0, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("rw_req",   0, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 1,0,16'h0000, 0,0,0));
    apply(mk("rw_wait",  0, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("rw_mid",   1, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("rw_stale", 0, 16'h0000, 0,1,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("rw_hit",   0, 16'h0000, 0,1,0,0, 16'h0000, 0,0,0, 1,0,16'h0000, 1,1,16'h0000, 0,0,0));

    // Halt during WAIT: access completes squashed, then HALT.
    apply(mk("hw_req",   0, 16'h0002, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 1,0,16'h0000, 0,0,0));
    apply(mk("hw_halt",  0, 16'h0002, 0,0,0,0, 16'h0000, 0,0,1, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("hw_done",  0, 16'h0002, 0,1,0,0, 16'h0000, 0,0,0, 1,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("hw_dump",  0, 16'h0004, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,1,1));
    apply(mk("hw_stay",  0, 16'h0004, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,1,0));

    // Exception with halt in IDLE: redirect taken, halt dropped.
    do_reset();
    apply(mk("eh_rst",   1, 16'h0000, 0,0,0,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,0));
    apply(mk("eh_idle",  0, 16'h0020, 0,0,0,0, 16'h0000, 1,0,1, 1,1,16'h0002, 0,0,16'h0000, 0,0,0));
    apply(mk("eh_after", 0, 16'h0002, 0,0,1,0, 16'h0000, 0,0,0, 0,0,16'h0000, 0,0,16'h0020, 0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
